// File: rtl/axi_perf_pkg.sv
// axi_perf_pkg: shared widths and the outstanding-write entry type
package axi_perf_pkg;
    localparam int AXI_LEN_W = 8;
    localparam int BEATS_W = 9;
    localparam int TS_MAX_W = 32;
    typedef struct packed {
        logic [TS_MAX_W-1:0] ts_issue;
        logic [AXI_LEN_W-1:0] len;
        logic wdone;
    } txn_entry_t;
endpackage

// File: rtl/axi_txn_store.sv
// axi_txn_store: circular entry store with AW (push), W (completion) and B (pop) pointers
module axi_txn_store
    import axi_perf_pkg::*;
#(
    parameter int MAX_OUTST = 8,
    localparam int PW = $clog2(MAX_OUTST) + 1,
    localparam int IW = PW - 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clr,
    input  logic                 push,
    input  logic [TS_MAX_W-1:0]  push_ts,
    input  logic [AXI_LEN_W-1:0] push_len,
    input  logic                 push_wdone,
    input  logic                 pop,
    input  logic                 wd_done,
    input  logic                 wd_skip,
    output logic [TS_MAX_W-1:0]  head_ts,
    output logic [AXI_LEN_W-1:0] head_len,
    output logic                 head_wdone,
    output logic [AXI_LEN_W-1:0] wd_len,
    output logic [PW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 wd_at_aw,
    output logic                 wd_is_head
);
    txn_entry_t mem [MAX_OUTST];
    logic [PW-1:0] aw_ptr, wd_ptr, b_ptr;

    assign count = aw_ptr - b_ptr;
    assign full = count == PW'(MAX_OUTST);
    assign empty = count == '0;
    assign wd_at_aw = wd_ptr == aw_ptr;
    assign wd_is_head = wd_ptr == b_ptr;
    assign {head_ts, head_len, head_wdone} = mem[b_ptr[IW-1:0]];
    assign wd_len = mem[wd_ptr[IW-1:0]].len;

    // Pointers: flushed by reset or clr, otherwise advanced by push, pop and W completion
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            aw_ptr <= '0;
            wd_ptr <= '0;
            b_ptr <= '0;
        end else begin
            aw_ptr <= aw_ptr + PW'(push);
            b_ptr <= b_ptr + PW'(pop);
            wd_ptr <= wd_ptr + PW'(wd_done) + PW'(wd_skip);
        end
    end

    // Entry writes; a push into the slot being retired overrides its wdone update
    always_ff @(posedge clk) begin
        if (wd_done) mem[wd_ptr[IW-1:0]].wdone <= 1'b1;
        if (push) mem[aw_ptr[IW-1:0]] <= '{ts_issue: push_ts, len: push_len, wdone: push_wdone};
    end
endmodule

// File: rtl/axi_wr_txn_tracker.sv
// axi_wr_txn_tracker: passive AXI4 write-port tap producing beat/transaction events and error flags
module axi_wr_txn_tracker
    import axi_perf_pkg::*;
#(
    parameter int MAX_OUTST = 8,
    parameter int TS_W = 16,
    localparam int PW = $clog2(MAX_OUTST) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 clr,
    input  logic                 aw_valid,
    input  logic                 aw_ready,
    input  logic [AXI_LEN_W-1:0] aw_len,
    input  logic                 w_valid,
    input  logic                 w_ready,
    input  logic                 w_last,
    input  logic                 b_valid,
    input  logic                 b_ready,
    output logic                 beat_evt,
    output logic                 txn_evt,
    output logic [TS_W-1:0]      txn_lat,
    output logic [BEATS_W-1:0]   txn_beats,
    output logic [PW-1:0]        outstanding,
    output logic                 overflow,
    output logic                 proto_err
);
    logic aw_hs, w_hs, wl_hs, b_hs, push, pop, w_chk, w_skip, early_inc;
    logic full, empty, wd_at_aw, wd_is_head, head_wdone, done_at_b, len_bad;
    logic [TS_W-1:0] ts;
    logic [BEATS_W-1:0] bcnt;
    logic [2:0] early_cnt;
    logic [AXI_LEN_W-1:0] wd_len, head_len;
    logic [TS_MAX_W-1:0] head_ts, lat_full;
    logic unused_lat;

    assign aw_hs = enable & aw_valid & aw_ready;
    assign w_hs = enable & w_valid & w_ready;
    assign wl_hs = w_hs & w_last;
    assign b_hs = enable & b_valid & b_ready;
    // a same-cycle pop frees a slot, so a push into a full store still succeeds
    assign pop = b_hs & ~empty;
    assign push = aw_hs & (~full | pop);
    assign w_chk = wl_hs & ~wd_at_aw;
    assign w_skip = push & (|early_cnt);
    assign early_inc = wl_hs & wd_at_aw & ((early_cnt != 3'd7) | w_skip);
    assign len_bad = bcnt != BEATS_W'(wd_len);
    assign done_at_b = head_wdone | (w_chk & wd_is_head);
    assign lat_full = TS_MAX_W'(ts) - head_ts;
    assign unused_lat = ^lat_full;

    axi_txn_store #(.MAX_OUTST(MAX_OUTST)) u_store (
        .clk(clk),
        .resetn(resetn),
        .clr(clr),
        .push(push),
        .push_ts(TS_MAX_W'(ts)),
        .push_len(aw_len),
        .push_wdone(w_skip),
        .pop(pop),
        .wd_done(w_chk),
        .wd_skip(w_skip),
        .head_ts(head_ts),
        .head_len(head_len),
        .head_wdone(head_wdone),
        .wd_len(wd_len),
        .count(outstanding),
        .full(full),
        .empty(empty),
        .wd_at_aw(wd_at_aw),
        .wd_is_head(wd_is_head)
    );

    // Free-running timestamp, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn) ts <= '0;
        else ts <= ts + TS_W'(1);
    end

    // Beat/early counters, sticky flags and registered event outputs
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            bcnt <= '0;
            early_cnt <= '0;
            beat_evt <= 1'b0;
            txn_evt <= 1'b0;
            txn_lat <= '0;
            txn_beats <= '0;
            overflow <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (w_hs) bcnt <= w_last ? '0 : bcnt + BEATS_W'(1);
            early_cnt <= early_cnt + 3'(early_inc) - 3'(w_skip);
            beat_evt <= w_hs;
            txn_evt <= pop;
            if (pop) begin
                txn_lat <= lat_full[TS_W-1:0];
                txn_beats <= BEATS_W'(head_len) + BEATS_W'(1);
            end
            overflow <= overflow | (aw_hs & full & ~pop);
            proto_err <= proto_err | (b_hs & empty) | (w_chk & len_bad) | (pop & ~done_at_b);
        end
    end
endmodule

// File: tb/tb_axi_wr_txn_tracker.sv
// tb_axi_wr_txn_tracker: scoreboard bench for the AXI write transaction tracker
module tb_axi_wr_txn_tracker;
    logic clk = 1'b0;
    logic resetn, enable, clr;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [7:0] aw_len;
    logic beat_evt, txn_evt, overflow, proto_err;
    logic [15:0] txn_lat;
    logic [8:0] txn_beats;
    logic [3:0] outstanding;

    typedef struct { int t; logic [7:0] len; } iss_t;
    typedef struct { logic [15:0] lat; logic [8:0] beats; } exp_t;
    iss_t iss_q[$];
    exp_t exp_q[$];
    exp_t mon_e;
    iss_t it;

    int checks = 0, failures = 0;
    int now = 0, w_exp = 0, beat_seen = 0, txn_seen = 0;
    logic [15:0] ts_m = '0;
    logic [15:0] last_lat = '0;
    logic [8:0] last_beats = '0;

    axi_wr_txn_tracker #(.MAX_OUTST(8), .TS_W(16)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready),
        .beat_evt(beat_evt), .txn_evt(txn_evt), .txn_lat(txn_lat), .txn_beats(txn_beats),
        .outstanding(outstanding), .overflow(overflow), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    // One clock: the model sees exactly what the DUT samples at this edge
    task automatic step();
        @(posedge clk);
        ts_m = resetn ? ts_m + 16'd1 : 16'd0;
        if (!resetn || clr) begin
            iss_q.delete();
        end else if (enable) begin
            if (w_valid && w_ready) w_exp++;
            if (b_valid && b_ready && iss_q.size() != 0) begin
                it = iss_q.pop_front();
                exp_q.push_back('{lat: 16'(now - it.t), beats: 9'(it.len) + 9'd1});
            end
            if (aw_valid && aw_ready && iss_q.size() < 8) iss_q.push_back('{t: now, len: aw_len});
        end
        now++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_aw(input logic [7:0] len);
        aw_valid = 1'b1;
        aw_len = len;
        step();
        aw_valid = 1'b0;
    endtask

    task automatic do_w(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            w_valid = 1'b1;
            w_last = (i == last_at);
            step();
        end
        w_valid = 1'b0;
        w_last = 1'b0;
    endtask

    task automatic do_b();
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (beat_evt) beat_seen++;
        if (txn_evt) begin
            txn_seen++;
            if (exp_q.size() == 0) begin
                chk("txn_unexpected", 32'(txn_evt), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("txn_lat", 32'(txn_lat), 32'(mon_e.lat));
                chk("txn_beats", 32'(txn_beats), 32'(mon_e.beats));
                last_lat = txn_lat;
                last_beats = txn_beats;
            end
        end
    end

    initial begin
        resetn = 1'b0; enable = 1'b1; clr = 1'b0;
        aw_valid = 1'b0; aw_ready = 1'b1; aw_len = '0;
        w_valid = 1'b0; w_ready = 1'b1; w_last = 1'b0;
        b_valid = 1'b0; b_ready = 1'b1;
        idle(5);
        chk("rst_beat_evt", 32'(beat_evt), 0);
        chk("rst_txn_evt", 32'(txn_evt), 0);
        chk("rst_txn_lat", 32'(txn_lat), 0);
        chk("rst_txn_beats", 32'(txn_beats), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        resetn = 1'b1;

        do_aw(8'd3);
        do_w(4, 4);
        idle(5);
        do_b();
        idle(2);
        chk("single_beats", beat_seen, 4);
        chk("single_txns", txn_seen, 1);
        chk("single_lat", 32'(last_lat), 10);
        chk("single_len", 32'(last_beats), 4);
        chk("single_outst", 32'(outstanding), 0);
        chk("single_stickies", 32'({overflow, proto_err}), 0);

        for (int i = 0; i < 8; i++) begin
            do_aw(8'(i));
            do_w(i + 1, i + 1);
        end
        chk("fill_outst", 32'(outstanding), 8);
        chk("fill_no_ovf", 32'(overflow), 0);
        do_aw(8'd0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_outst", 32'(outstanding), 8);
        for (int i = 0; i < 8; i++) do_b();
        idle(2);
        chk("drain_outst", 32'(outstanding), 0);
        chk("drain_txns", txn_seen, 9);
        chk("drain_proto", 32'(proto_err), 0);
        do_clr();
        chk("clr_ovf", 32'(overflow), 0);

        do_w(2, 2);
        do_aw(8'd1);
        idle(3);
        do_b();
        idle(2);
        chk("early_proto", 32'(proto_err), 0);
        chk("early_beats", 32'(last_beats), 2);
        chk("early_txns", txn_seen, 10);

        do_b();
        idle(1);
        chk("b_empty_proto", 32'(proto_err), 1);
        chk("b_empty_no_txn", txn_seen, 10);
        do_clr();
        chk("clr_proto", 32'(proto_err), 0);
        do_aw(8'd3);
        do_w(2, 2);
        chk("short_burst_proto", 32'(proto_err), 1);
        do_clr();
        chk("clr_outst", 32'(outstanding), 0);
        clr = 1'b1;
        b_valid = 1'b1;
        step();
        clr = 1'b0;
        b_valid = 1'b0;
        chk("clr_wins", 32'(proto_err), 0);
        enable = 1'b0;
        do_aw(8'd0);
        do_b();
        enable = 1'b1;
        chk("disabled_outst", 32'(outstanding), 0);
        chk("disabled_proto", 32'(proto_err), 0);

        for (int g = 0; g < 70000 && ts_m != 16'hFFF0; g++) step();
        do_aw(8'd0);
        do_w(1, 1);
        idle(30);
        do_b();
        idle(2);
        chk("wrap_lat", 32'(last_lat), 32);
        chk("wrap_txns", txn_seen, 11);

        do_aw(8'd0);
        do_w(1, 1);
        chk("same_pre_outst", 32'(outstanding), 1);
        aw_valid = 1'b1;
        aw_len = 8'd0;
        b_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        b_valid = 1'b0;
        chk("same_outst", 32'(outstanding), 1);
        idle(1);
        chk("same_txns", txn_seen, 12);
        do_w(1, 1);
        idle(3);
        do_b();
        idle(2);
        chk("final_outst", 32'(outstanding), 0);
        chk("final_txns", txn_seen, 13);
        chk("final_beats", beat_seen, w_exp);
        chk("final_pending", exp_q.size(), 0);
        chk("final_stickies", 32'({overflow, proto_err}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
